pbus_phy: RTL and testbench

//  Slave-side physical endpoint of the parameterized PBus request/grant bus.

---
 rtl/pbus_phy.sv | 95 +++++++++
 tb/tb_pbus_phy.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pbus_phy.sv
// PBus slave endpoint: 4-phase req/grant handshake driving one read or write
// on a local register bank, with registered grant/rdata/rvalid/err outputs.
module pbus_phy #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             we,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             grant,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0] LIMIT = (WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HOLD
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] wd_q;
    logic             we_q;
    logic             in_range;
    logic [IW-1:0]    idx;

    assign in_range = ({1'b0, a_q} < LIMIT);
    assign idx      = a_q[IW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            grant  <= 1'b0;
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
            a_q    <= '0;
            wd_q   <= '0;
            we_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    grant  <= 1'b0;
                    rvalid <= 1'b0;
                    err    <= 1'b0;
                    if (req) begin
                        a_q   <= addr;
                        wd_q  <= wdata;
                        we_q  <= we;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (in_range) begin
                        if (we_q) begin
                            regs[idx] <= wd_q;
                        end else begin
                            rdata <= regs[idx];
                        end
                        err <= 1'b0;
                    end else begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end
                    grant  <= 1'b1;
                    rvalid <= ~we_q;
                    state  <= HOLD;
                end
                HOLD: begin
                    if (!req) begin
                        grant  <= 1'b0;
                        rvalid <= 1'b0;
                        err    <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pbus_phy.sv
// Directed bench for pbus_phy: 8-bit and 16-bit instances, scoreboard of
// expected completions checked with immediate assertions.
module tb_pbus_phy;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req8 = 1'b0;
    logic        req16 = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;

    logic        grant8, rvalid8, err8;
    logic [7:0]  rdata8;
    logic        grant16, rvalid16, err16;
    logic [15:0] rdata16;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] rdata;
        logic        rvalid;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  m8  [16];
    logic [15:0] m16 [16];
    logic [15:0] last8 = '0;
    logic [15:0] last16 = '0;

    pbus_phy #(.WIDTH(8), .DEPTH(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .we(we),
        .addr(addr[7:0]), .wdata(wdata[7:0]),
        .grant(grant8), .rdata(rdata8), .rvalid(rvalid8), .err(err8)
    );

    pbus_phy #(.WIDTH(16), .DEPTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .req(req16), .we(we),
        .addr(addr), .wdata(wdata),
        .grant(grant16), .rdata(rdata16), .rvalid(rvalid16), .err(err16)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic g(input bit wide);
        return wide ? grant16 : grant8;
    endfunction

    function automatic logic [15:0] rd(input bit wide);
        return wide ? rdata16 : {8'h00, rdata8};
    endfunction

    function automatic logic rv(input bit wide);
        return wide ? rvalid16 : rvalid8;
    endfunction

    function automatic logic er(input bit wide);
        return wide ? err16 : err8;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            m8[i]  = '0;
            m16[i] = '0;
        end
        last8  = '0;
        last16 = '0;
    endtask

    // Predict the completion of one transaction and push it to the scoreboard.
    task automatic predict(input bit wide, input logic w, input logic [15:0] a, input logic [15:0] d);
        exp_t        e;
        logic [15:0] ea;
        logic        inr;
        ea  = wide ? a : {8'h00, a[7:0]};
        inr = (ea < 16);
        if (!inr)
            e.rdata = '0;
        else if (w)
            e.rdata = wide ? last16 : last8;
        else
            e.rdata = wide ? m16[ea[3:0]] : {8'h00, m8[ea[3:0]]};
        if (w && inr) begin
            if (wide) m16[ea[3:0]] = d;
            else      m8[ea[3:0]]  = d[7:0];
        end
        e.rvalid = !w;
        e.err    = !inr;
        if (wide) last16 = e.rdata;
        else      last8  = e.rdata;
        sb.push_back(e);
    endtask

    task automatic set_req(input bit wide, input logic v);
        if (wide) req16 = v;
        else      req8  = v;
    endtask

    task automatic txn(input bit wide, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input int hold);
        exp_t e;
        int   cyc;
        predict(wide, w, a, d);
        @(negedge clk);
        we = w; addr = a; wdata = d;
        set_req(wide, 1'b1);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!g(wide) && cyc < 10);
        chk("grant_latency", cyc, 2);
        e = sb.pop_front();
        chk("grant", g(wide), 1'b1);
        chk("rdata", rd(wide), e.rdata);
        chk("rvalid", rv(wide), e.rvalid);
        chk("err", er(wide), e.err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            addr = 16'($urandom); wdata = 16'($urandom); we = 1'($urandom);
            @(posedge clk); #1;
            chk("hold_grant", g(wide), 1'b1);
            chk("hold_rdata", rd(wide), e.rdata);
        end
        @(negedge clk);
        set_req(wide, 1'b0);
        @(posedge clk); #1;
        chk("drop_grant", g(wide), 1'b0);
        chk("drop_rvalid", rv(wide), 1'b0);
        chk("drop_err", er(wide), 1'b0);
        chk("drop_rdata_kept", rd(wide), e.rdata);
    endtask

    initial begin
        exp_t e;
        clear_model();
        #12;
        chk("rst_grant8", grant8, 1'b0);
        chk("rst_rdata8", rdata8, 8'h00);
        chk("rst_rvalid8", rvalid8, 1'b0);
        chk("rst_err8", err8, 1'b0);
        chk("rst_grant16", grant16, 1'b0);
        chk("rst_rdata16", rdata16, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // basic write then read-back
        txn(0, 1'b1, 16'd3, 16'h00A5, 0);
        txn(0, 1'b0, 16'd3, 16'h0000, 0);

        // back-to-back
        txn(0, 1'b1, 16'd0, 16'h0011, 0);
        txn(0, 1'b1, 16'd1, 16'h0022, 0);
        txn(0, 1'b0, 16'd0, 16'h0000, 0);
        txn(0, 1'b0, 16'd1, 16'h0000, 0);

        // out-of-range accesses leave the bank untouched
        txn(0, 1'b0, 16'd16, 16'h0000, 0);
        txn(0, 1'b1, 16'd16, 16'h00FF, 0);
        txn(0, 1'b1, 16'h0083, 16'h00EE, 0);
        txn(0, 1'b0, 16'd0, 16'h0000, 0);
        txn(0, 1'b0, 16'd3, 16'h0000, 0);
        txn(0, 1'b0, 16'd15, 16'h0000, 0);

        // long hold with inputs changing underneath
        txn(0, 1'b0, 16'd1, 16'h0000, 10);

        // req dropped while in ACCESS: transaction still completes
        predict(0, 1'b0, 16'd3, 16'h0000);
        @(negedge clk);
        we = 1'b0; addr = 16'd3; req8 = 1'b1;
        @(posedge clk); #1;
        chk("early_access_grant", grant8, 1'b0);
        @(negedge clk);
        req8 = 1'b0;
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("early_grant", grant8, 1'b1);
        chk("early_rdata", {8'h00, rdata8}, e.rdata);
        chk("early_rvalid", rvalid8, e.rvalid);
        @(posedge clk); #1;
        chk("early_release", grant8, 1'b0);

        // reset during ACCESS of a write aborts it
        @(negedge clk);
        we = 1'b1; addr = 16'd2; wdata = 16'h005A; req8 = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_grant", grant8, 1'b0);
        chk("midrst_rdata", rdata8, 8'h00);
        chk("midrst_rvalid", rvalid8, 1'b0);
        chk("midrst_err", err8, 1'b0);
        @(negedge clk);
        req8 = 1'b0;
        rst_n = 1'b1;
        clear_model();
        txn(0, 1'b0, 16'd2, 16'h0000, 0);
        txn(0, 1'b0, 16'd3, 16'h0000, 0);

        // 16-bit instance
        txn(1, 1'b1, 16'd15, 16'hBEEF, 0);
        txn(1, 1'b0, 16'd15, 16'h0000, 0);
        txn(1, 1'b0, 16'h0100, 16'h0000, 0);
        txn(1, 1'b1, 16'h0010, 16'h1234, 0);
        txn(1, 1'b0, 16'd0, 16'h0000, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
